// File: rtl/sync_mem_arbiter_pkg.sv
// Shared definitions for the synchronous memory arbiter: arbitration mode
// constants, the in-flight tag carried through the read-latency pipe, and
// small index helpers used by the arbiter and the top level.
package sync_mem_arbiter_pkg;

  // Arbitration modes
  localparam int ARB_RR    = 0;  // round-robin, pointer-based search
  localparam int ARB_FIXED = 1;  // port 0 highest, starvation allowed

  // Largest supported port count and the tag index width that covers it
  localparam int MAX_PORTS = 8;
  localparam int TAG_IDX_W = 3;

  // One in-flight access: issued port and whether it was a write
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
    logic                 is_write;
  } inflight_t;

  // Width of a port index for n ports, never less than one bit
  function automatic int port_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // (base + off) mod n for base < n and off < n
  function automatic int wrap_index(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/sync_mem_arbiter_rr_arbiter.sv
// Request arbiter for the shared memory front end. Produces a one-hot grant
// combinationally from the request vector and, in round-robin mode, a
// priority pointer that advances past each granted port.
module rr_arbiter
  import sync_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = ARB_RR,
  localparam int IDX_W    = port_idx_width(NUM_PORTS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_any,
  output logic [IDX_W-1:0]     ptr
);

  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] search_base;

  // Fixed priority always searches from port 0; round-robin from the pointer
  always_comb begin
    search_base = '0;
    if (ARB_MODE == ARB_RR) begin
      search_base = ptr;
    end
  end

  // First requesting port found walking up from search_base, wrapping once.
  // Nothing is granted while reset is high.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (!reset) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (!grant_any && req[i] &&
              (i == wrap_index(int'(search_base), k, NUM_PORTS))) begin
            grant[i]  = 1'b1;
            grant_idx = IDX_W'(i);
            grant_any = 1'b1;
          end
        end
      end
    end
  end

  // Pointer moves to the port after the one just granted; holds otherwise
  always_comb begin
    ptr_next = ptr;
    if ((ARB_MODE == ARB_RR) && grant_any) begin
      if (int'(grant_idx) >= NUM_PORTS - 1) begin
        ptr_next = '0;
      end else begin
        ptr_next = grant_idx + 1'b1;
      end
    end
  end

  // Pointer register
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/sync_mem_arbiter.sv
// N-port front end for a single-ported synchronous RAM. Accepts at most one
// request per cycle, drives the RAM from the granted port, and routes each
// completion back to its issuing port after READ_LATENCY cycles.
//
// Handshake: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high. The requester keeps valid, wren, addr and data
// stable until that cycle and never drops valid early. req_ready is one-hot
// or zero. Responses are single-cycle pulses on rsp_valid with no back-pressure;
// rsp_data is mem_q for reads and zero for write acks and idle cycles.
module sync_mem_arbiter
  import sync_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = ARB_RR
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_wren,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic [DATA_WIDTH-1:0]           mem_data,
  output logic                            mem_wren,
  input  logic [DATA_WIDTH-1:0]           mem_q
);

  localparam int IDX_W = port_idx_width(NUM_PORTS);

  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [IDX_W-1:0]     arb_ptr;

  inflight_t issue_tag;
  inflight_t out_tag;
  inflight_t pipe [READ_LATENCY];

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .ARB_MODE  (ARB_MODE)
  ) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any),
    .ptr       (arb_ptr)
  );

  // The grant is the accept: a granted port is by construction valid
  assign req_ready = grant;

  // Route the granted port onto the RAM bus; idle bus is all zero
  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        mem_address = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        mem_wren    = req_wren[i];
      end
    end
  end

  // Tag describing this cycle's transfer, if any
  always_comb begin
    issue_tag          = '0;
    issue_tag.valid    = grant_any;
    issue_tag.idx      = TAG_IDX_W'(grant_idx);
    issue_tag.is_write = mem_wren;
  end

  // In-flight pipe, one stage per cycle of RAM read latency. Reset drops
  // every entry so no response from before reset is ever emitted.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= issue_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign out_tag = pipe[READ_LATENCY-1];

  // Output stage: pulse the issuing port, pass read data through
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rsp_valid[i] = out_tag.valid && (int'(out_tag.idx) == i);
    end
    if (out_tag.valid && !out_tag.is_write) begin
      rsp_data = mem_q;
    end
  end

  // The arbiter never grants more than one port
  a_grant_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(grant));

  // The pointer always names an existing port
  a_ptr_range: assert property (@(posedge clock) disable iff (reset) int'(arb_ptr) < NUM_PORTS);

endmodule

// File: tb/tb_sync_mem_arbiter.sv
// Bench for sync_mem_arbiter: a 4-port round-robin instance with read
// latency 2 and a 2-port fixed-priority instance with read latency 1, each
// attached to a write-first RAM model. Directed vectors with hand-computed
// grants and data; a per-instance monitor checks every response cycle.
module tb_sync_mem_arbiter;

  localparam int A_N   = 4;
  localparam int A_LAT = 2;
  localparam int B_N   = 2;
  localparam int B_LAT = 1;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int EW    = 56;  // {due[15:0], port_onehot[7:0], data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  logic mon_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: RR, 4 ports, latency 2 ----------------
  logic [A_N-1:0]    a_valid, a_wren, a_ready, a_rsp_valid;
  logic [AW-1:0]     a_addr [A_N];
  logic [DW-1:0]     a_data [A_N];
  logic [A_N*AW-1:0] a_addr_f;
  logic [A_N*DW-1:0] a_data_f;
  logic [DW-1:0]     a_rsp_data, a_mem_data, a_mem_q;
  logic [AW-1:0]     a_mem_address;
  logic              a_mem_wren;
  logic [DW-1:0]     ram_a [0:4095];
  logic [DW-1:0]     qa [A_LAT];
  logic [DW-1:0]     a_word [A_N];

  always_comb begin
    a_addr_f = '0;
    a_data_f = '0;
    for (int i = 0; i < A_N; i++) begin
      a_addr_f[i*AW +: AW] = a_addr[i];
      a_data_f[i*DW +: DW] = a_data[i];
    end
  end

  sync_mem_arbiter #(
    .NUM_PORTS(A_N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .READ_LATENCY(A_LAT), .ARB_MODE(0)
  ) dut_a (
    .clock(clk), .reset(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_wren(a_wren),
    .req_addr(a_addr_f), .req_data(a_data_f),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
    .mem_address(a_mem_address), .mem_data(a_mem_data),
    .mem_wren(a_mem_wren), .mem_q(a_mem_q)
  );

  always @(posedge clk) begin
    if (a_mem_wren) ram_a[a_mem_address] <= a_mem_data;
    qa[0] <= a_mem_wren ? a_mem_data : ram_a[a_mem_address];
    for (int i = 1; i < A_LAT; i++) qa[i] <= qa[i-1];
  end
  assign a_mem_q = qa[A_LAT-1];

  // ---------------- instance B: fixed priority, 2 ports, latency 1 ----------------
  logic [B_N-1:0]    b_valid, b_wren, b_ready, b_rsp_valid;
  logic [AW-1:0]     b_addr [B_N];
  logic [DW-1:0]     b_data [B_N];
  logic [B_N*AW-1:0] b_addr_f;
  logic [B_N*DW-1:0] b_data_f;
  logic [DW-1:0]     b_rsp_data, b_mem_data, b_mem_q;
  logic [AW-1:0]     b_mem_address;
  logic              b_mem_wren;
  logic [DW-1:0]     ram_b [0:4095];
  logic [DW-1:0]     qb [B_LAT];

  always_comb begin
    b_addr_f = '0;
    b_data_f = '0;
    for (int i = 0; i < B_N; i++) begin
      b_addr_f[i*AW +: AW] = b_addr[i];
      b_data_f[i*DW +: DW] = b_data[i];
    end
  end

  sync_mem_arbiter #(
    .NUM_PORTS(B_N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .READ_LATENCY(B_LAT), .ARB_MODE(1)
  ) dut_b (
    .clock(clk), .reset(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_wren(b_wren),
    .req_addr(b_addr_f), .req_data(b_data_f),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .mem_address(b_mem_address), .mem_data(b_mem_data),
    .mem_wren(b_mem_wren), .mem_q(b_mem_q)
  );

  always @(posedge clk) begin
    if (b_mem_wren) ram_b[b_mem_address] <= b_mem_data;
    qb[0] <= b_mem_wren ? b_mem_data : ram_b[b_mem_address];
    for (int i = 1; i < B_LAT; i++) qb[i] <= qb[i-1];
  end
  assign b_mem_q = qb[B_LAT-1];

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_qa[$];
  logic [EW-1:0] exp_qb[$];
  logic [EW-1:0] ea_e, eb_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_a();
    a_valid = '0;
    a_wren  = '0;
    for (int i = 0; i < A_N; i++) begin
      a_addr[i] = '0;
      a_data[i] = '0;
    end
  endtask

  task automatic set_a(input int p, input logic v, input logic w,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_valid[p] = v;
    a_wren[p]  = w;
    a_addr[p]  = ad;
    a_data[p]  = d;
  endtask

  // Check grant and RAM bus for this cycle; queue the expected response
  task automatic step_a(input logic [A_N-1:0] exp_rdy, input logic [DW-1:0] exp_d, input bit push);
    int g;
    logic [AW-1:0] xa;
    logic [DW-1:0] xd;
    logic xw;
    #1;
    check("a_ready", a_ready, exp_rdy);
    g = -1;
    for (int i = 0; i < A_N; i++) if (exp_rdy[i]) g = i;
    xa = '0; xd = '0; xw = 1'b0;
    if (g >= 0) begin
      xa = a_addr[g]; xd = a_data[g]; xw = a_wren[g];
    end
    check("a_mem_address", a_mem_address, xa);
    check("a_mem_data", a_mem_data, xd);
    check("a_mem_wren", a_mem_wren, xw);
    if (g >= 0 && push) exp_qa.push_back({16'(cyc + A_LAT), 8'(exp_rdy), exp_d});
  endtask

  task automatic clear_b();
    b_valid = '0;
    b_wren  = '0;
    for (int i = 0; i < B_N; i++) begin
      b_addr[i] = '0;
      b_data[i] = '0;
    end
  endtask

  task automatic set_b(input int p, input logic v, input logic w,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d);
    b_valid[p] = v;
    b_wren[p]  = w;
    b_addr[p]  = ad;
    b_data[p]  = d;
  endtask

  task automatic step_b(input logic [B_N-1:0] exp_rdy, input logic [DW-1:0] exp_d, input bit push);
    int g;
    logic [AW-1:0] xa;
    logic [DW-1:0] xd;
    logic xw;
    #1;
    check("b_ready", b_ready, exp_rdy);
    g = -1;
    for (int i = 0; i < B_N; i++) if (exp_rdy[i]) g = i;
    xa = '0; xd = '0; xw = 1'b0;
    if (g >= 0) begin
      xa = b_addr[g]; xd = b_data[g]; xw = b_wren[g];
    end
    check("b_mem_address", b_mem_address, xa);
    check("b_mem_data", b_mem_data, xd);
    check("b_mem_wren", b_mem_wren, xw);
    if (g >= 0 && push) exp_qb.push_back({16'(cyc + B_LAT), 8'(exp_rdy), exp_d});
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_qa.size() > 0 && int'(exp_qa[0][EW-1 -: 16]) == cyc) begin
        ea_e = exp_qa.pop_front();
        check("a_rsp_valid", a_rsp_valid, ea_e[DW+7:DW]);
        check("a_rsp_data", a_rsp_data, ea_e[DW-1:0]);
      end else begin
        check("a_rsp_idle_valid", a_rsp_valid, 0);
        check("a_rsp_idle_data", a_rsp_data, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_qb.size() > 0 && int'(exp_qb[0][EW-1 -: 16]) == cyc) begin
        eb_e = exp_qb.pop_front();
        check("b_rsp_valid", b_rsp_valid, eb_e[DW+7:DW]);
        check("b_rsp_data", b_rsp_data, eb_e[DW-1:0]);
      end else begin
        check("b_rsp_idle_valid", b_rsp_valid, 0);
        check("b_rsp_idle_data", b_rsp_data, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    a_word[0] = 32'hA0A0A0A0;
    a_word[1] = 32'h11110001;
    a_word[2] = 32'h22220002;
    a_word[3] = 32'h33330003;
    rst = 1'b1;
    clear_a();
    clear_b();
    repeat (2) tick();

    // reset held: requests are never accepted
    a_valid = '1;
    b_valid = '1;
    step_a('0, '0, 0);
    step_b('0, '0, 0);
    tick();

    // first cycle out of reset: everything idle
    rst = 1'b0;
    clear_a();
    clear_b();
    mon_en = 1'b1;
    step_a('0, '0, 0);
    step_b('0, '0, 0);
    tick();

    // A: write then immediate read of same address (pointer 0 -> 2 -> 2)
    set_a(1, 1, 1, 12'h010, 32'hDEADBEEF); step_a(4'b0010, 32'h0, 1); tick();
    set_a(1, 1, 0, 12'h010, 32'h0);        step_a(4'b0010, 32'hDEADBEEF, 1); tick();
    clear_a();                              step_a(4'b0000, 32'h0, 0); tick();
    // port 0 write/read 0x0FF (pointer 2 -> 1 -> 1)
    set_a(0, 1, 1, 12'h0FF, 32'h12345678); step_a(4'b0001, 32'h0, 1); tick();
    set_a(0, 1, 0, 12'h0FF, 32'h0);        step_a(4'b0001, 32'h12345678, 1); tick();
    // fill addresses 0..3 (pointer 1 -> 0 -> 3 -> 2 -> 1)
    clear_a(); set_a(3, 1, 1, 12'h003, a_word[3]); step_a(4'b1000, 32'h0, 1); tick();
    clear_a(); set_a(2, 1, 1, 12'h002, a_word[2]); step_a(4'b0100, 32'h0, 1); tick();
    clear_a(); set_a(1, 1, 1, 12'h001, a_word[1]); step_a(4'b0010, 32'h0, 1); tick();
    clear_a(); set_a(0, 1, 1, 12'h000, a_word[0]); step_a(4'b0001, 32'h0, 1); tick();

    // all four ports reading continuously: grants 1,2,3,0,1,2,3,0
    clear_a();
    for (int i = 0; i < A_N; i++) set_a(i, 1, 0, 12'(i), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step_a(4'(1 << ((1 + k) % A_N)), a_word[(1 + k) % A_N], 1);
      tick();
    end
    clear_a();
    step_a(4'b0000, 32'h0, 0); tick();
    step_a(4'b0000, 32'h0, 0); tick();

    // read accepted, then reset next cycle: its response must never appear
    set_a(2, 1, 0, 12'h002, 32'h0); step_a(4'b0100, 32'h0, 0); tick();
    for (int i = 0; i < A_N; i++) set_a(i, 1, 0, 12'(i), 32'h0);
    rst = 1'b1;
    step_a(4'b0000, 32'h0, 0); tick();
    rst = 1'b0;
    // pointer back at 0 after reset (it was 3 before)
    step_a(4'b0001, a_word[0], 1); tick();
    clear_a();
    step_a(4'b0000, 32'h0, 0); tick();
    step_a(4'b0000, 32'h0, 0); tick();

    // B: fixed priority
    set_b(1, 1, 1, 12'h020, 32'hCAFEF00D); step_b(2'b10, 32'h0, 1); tick();
    clear_b(); set_b(0, 1, 1, 12'h021, 32'h0BADC0DE); step_b(2'b01, 32'h0, 1); tick();
    clear_b();
    set_b(0, 1, 0, 12'h021, 32'h0);
    set_b(1, 1, 0, 12'h020, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step_b(2'b01, 32'h0BADC0DE, 1);
      tick();
    end
    set_b(0, 0, 0, 12'h000, 32'h0);
    step_b(2'b10, 32'hCAFEF00D, 1); tick();
    clear_b();
    step_b(2'b00, 32'h0, 0); tick();

    // let outstanding responses drain, bounded
    for (int k = 0; k < 10; k++) begin
      if (exp_qa.size() > 0 || exp_qb.size() > 0) tick();
    end
    check("drain_pending", 64'(exp_qa.size() + exp_qb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
